// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the dual-line pulse transmitter: state encoding,
// symbol field layout and frame-length helpers.
package pulse_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  // Symbol layout: [1:0] lag code, [2] selects which line leads.
  localparam int SYM_W    = 3;
  localparam int LAG_LSB  = 0;
  localparam int LAG_W    = 2;
  localparam int LEAD_BIT = 2;
  localparam int MAX_CODE = 3;

  // SEND is sized for the largest lag so every frame has the same length.
  function automatic int send_len(input int pulse_w, input int dly_unit);
    return MAX_CODE * dly_unit + pulse_w;
  endfunction

  // Counter must reach the longer of SEND and GUARD without wrapping.
  function automatic int cnt_width(input int slen, input int gap);
    int m;
    m = (slen > gap) ? slen : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dual_line_pulse_tx_if.sv
// Symbol handshake plus the two detector drive lines and frame status.
interface dual_line_pulse_tx_if;
  import pulse_tx_pkg::*;

  logic             sym_valid;
  logic [SYM_W-1:0] sym_data;
  logic             sym_ready;
  logic             tx_in;
  logic             tx_in1;
  logic             busy;
  logic             done;

  // Transmitter side: consumes symbols, drives the lines.
  modport slave (
    input  sym_valid, sym_data,
    output sym_ready, tx_in, tx_in1, busy, done
  );

  // Symbol source / observer side.
  modport master (
    output sym_valid, sym_data,
    input  sym_ready, tx_in, tx_in1, busy, done
  );

endinterface

// File: rtl/pulse_window.sv
// In-window comparator: flags start <= cnt < start + PULSE_W.
module pulse_window #(
  parameter int CNT_W   = 3,
  parameter int PULSE_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] start,
  output logic             in_win
);

  // One extra bit so start + PULSE_W cannot overflow the compare.
  logic [CNT_W:0] win_end;

  assign win_end = {1'b0, start} + (CNT_W+1)'(PULSE_W);
  assign in_win  = (cnt >= start) && ({1'b0, cnt} < win_end);

endmodule

// File: rtl/dual_line_pulse_tx.sv
// Dual-line pulse transmitter: each accepted symbol becomes a fixed-length
// frame with a leading pulse and a lagging pulse skewed by the lag code.
// All outputs are registered from next-state values so the first pulse
// appears in the cycle right after the accepting edge.
module dual_line_pulse_tx
  import pulse_tx_pkg::*;
#(
  parameter int PULSE_W  = 2,
  parameter int DLY_UNIT = 1,
  parameter int GAP      = 3
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  dual_line_pulse_tx_if.slave bus
);

  localparam int SEND_LEN = send_len(PULSE_W, DLY_UNIT);
  localparam int CNT_W    = cnt_width(SEND_LEN, GAP);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_SEND  = ST_SEND;
  localparam logic [1:0] S_GUARD = ST_GUARD;

  localparam logic [CNT_W-1:0] SEND_LAST  = CNT_W'(SEND_LEN - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GAP - 1);

  logic [1:0]       rst_sync;
  logic             rst_i;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SYM_W-1:0] sym_q, sym_d;
  logic [CNT_W-1:0] off_d;
  logic             done_d;
  logic             lead_win, lag_win;
  logic             lead_line, lag_line;
  logic             tx_in_d, tx_in1_d;
  logic             tx_in_q, tx_in1_q, busy_q, done_q, sym_ready_q;

  // Reset asserts at once but releases only after two clean clock edges.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rst_sync <= 2'b11;
    else         rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_i = rst_sync[1];

  // Next-state, counter reload and symbol capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.sym_valid && sym_ready_q) begin
          state_d = S_SEND;
          cnt_d   = '0;
          sym_d   = bus.sym_data;
        end
      end
      S_SEND: begin
        if (cnt_q == SEND_LAST) begin
          state_d = S_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lag offset of the symbol that will be on the lines next cycle.
  assign off_d = CNT_W'(sym_d[LAG_LSB +: LAG_W]) * CNT_W'(DLY_UNIT);

  pulse_window #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) u_lead_win (
    .cnt    (cnt_d),
    .start  ('0),
    .in_win (lead_win)
  );

  pulse_window #(.CNT_W(CNT_W), .PULSE_W(PULSE_W)) u_lag_win (
    .cnt    (cnt_d),
    .start  (off_d),
    .in_win (lag_win)
  );

  // Pulses only exist in SEND; steering follows the lead-select bit.
  assign lead_line = (state_d == S_SEND) && lead_win;
  assign lag_line  = (state_d == S_SEND) && lag_win;
  assign tx_in_d   = sym_d[LEAD_BIT] ? lag_line  : lead_line;
  assign tx_in1_d  = sym_d[LEAD_BIT] ? lead_line : lag_line;

  // FSM state and frame counter.
  always_ff @(posedge sys_clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Symbol holding register; only meaningful while a frame is in flight.
  always_ff @(posedge sys_clk) begin
    sym_q <= sym_d;
  end

  // Registered outputs.
  always_ff @(posedge sys_clk or posedge rst_i) begin
    if (rst_i) begin
      tx_in_q     <= 1'b0;
      tx_in1_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sym_ready_q <= 1'b1;
    end else begin
      tx_in_q     <= tx_in_d;
      tx_in1_q    <= tx_in1_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= done_d;
      sym_ready_q <= (state_d == S_IDLE);
    end
  end

  assign bus.tx_in     = tx_in_q;
  assign bus.tx_in1    = tx_in1_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sym_ready = sym_ready_q;

endmodule

// File: tb/tb_dual_line_pulse_tx.sv
// Bench for dual_line_pulse_tx: a default-parameter instance and a
// PULSE_W=1/DLY_UNIT=4/GAP=1 instance, both checked every cycle against a
// frame-level reference model, a skew decoder and directed waveform traces.
module tb_dual_line_pulse_tx;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;

  always #5 sys_clk = ~sys_clk;

  dual_line_pulse_tx_if bif0 ();
  dual_line_pulse_tx_if bif1 ();

  logic [1:0]      sv = '0;
  logic [1:0][2:0] sd = '0;
  logic [1:0][4:0] obs;  // {sym_ready, tx_in, tx_in1, busy, done}

  assign bif0.sym_valid = sv[0];
  assign bif0.sym_data  = sd[0];
  assign bif1.sym_valid = sv[1];
  assign bif1.sym_data  = sd[1];
  assign obs[0] = {bif0.sym_ready, bif0.tx_in, bif0.tx_in1, bif0.busy, bif0.done};
  assign obs[1] = {bif1.sym_ready, bif1.tx_in, bif1.tx_in1, bif1.busy, bif1.done};

  dual_line_pulse_tx u_dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bif0)
  );

  dual_line_pulse_tx #(.PULSE_W(1), .DLY_UNIT(4), .GAP(1)) u_dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bif1)
  );

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pw_of(input int id);  return (id == 0) ? 2 : 1; endfunction
  function automatic int du_of(input int id);  return (id == 0) ? 1 : 4; endfunction
  function automatic int gap_of(input int id); return (id == 0) ? 3 : 1; endfunction
  function automatic int len_of(input int id); return 3 * du_of(id) + pw_of(id); endfunction

  // Frame-level reference: k counts cycles since the accepting edge.
  bit       m_act  [2];
  bit       m_done [2];
  int       m_k    [2];
  bit [2:0] m_sym  [2];
  int       rel = 0;

  always @(posedge sys_clk) ecnt <= ecnt + 1;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rel <= 0;
      for (int id = 0; id < 2; id++) begin
        m_act[id]  <= 1'b0;
        m_done[id] <= 1'b0;
        m_k[id]    <= 0;
      end
    end else begin
      if (rel < 2) rel <= rel + 1;
      for (int id = 0; id < 2; id++) begin
        m_done[id] <= 1'b0;
        if (!m_act[id]) begin
          if (sv[id] && rel >= 2) begin
            m_act[id] <= 1'b1;
            m_k[id]   <= 1;
            m_sym[id] <= sd[id];
          end
        end else if (m_k[id] == len_of(id) + gap_of(id)) begin
          m_act[id]  <= 1'b0;
          m_done[id] <= 1'b1;
        end else begin
          m_k[id] <= m_k[id] + 1;
        end
      end
    end
  end

  function automatic logic [4:0] expect_outs(input int id);
    int  off;
    bit  lead, lag;
    if (!m_act[id]) return {1'b1, 3'b000, m_done[id]};
    off  = int'(m_sym[id][1:0]) * du_of(id);
    lead = (m_k[id] <= pw_of(id));
    lag  = (m_k[id] > off) && (m_k[id] <= off + pw_of(id));
    return m_sym[id][2] ? {1'b0, lag, lead, 2'b10} : {1'b0, lead, lag, 2'b10};
  endfunction

  // Per-cycle output check plus a detector-style decode of each frame.
  int fr_in  [2] = '{-1, -1};
  int fr_in1 [2] = '{-1, -1};

  always @(negedge sys_clk) begin
    for (int id = 0; id < 2; id++) begin
      chk($sformatf("outs%0d", id), 32'(obs[id]), 32'(expect_outs(id)));
      if (sys_rst) begin
        fr_in[id]  <= -1;
        fr_in1[id] <= -1;
      end else if (m_act[id]) begin
        if (obs[id][3] && fr_in[id]  < 0) fr_in[id]  <= m_k[id];
        if (obs[id][2] && fr_in1[id] < 0) fr_in1[id] <= m_k[id];
      end else if (m_done[id]) begin
        fr_in[id]  <= -1;
        fr_in1[id] <= -1;
        if (fr_in[id] < 0 || fr_in1[id] < 0) begin
          chk($sformatf("dec_seen%0d", id), 0, 1);
        end else if (fr_in[id] == fr_in1[id]) begin
          chk($sformatf("dec_code%0d", id), 0, 32'(m_sym[id][1:0]));
        end else begin
          int diff;
          diff = (fr_in[id] > fr_in1[id]) ? fr_in[id] - fr_in1[id] : fr_in1[id] - fr_in[id];
          chk($sformatf("dec_code%0d", id), 32'(diff / du_of(id)), 32'(m_sym[id][1:0]));
          chk($sformatf("dec_lead%0d", id), 32'(fr_in1[id] < fr_in[id]), 32'(m_sym[id][2]));
        end
      end
    end
  end

  task automatic wait_idle(input int id);
    for (int c = 0; c < 60 && m_act[id]; c++) @(negedge sys_clk);
    chk($sformatf("idle_to%0d", id), 32'(m_act[id]), 0);
  endtask

  // Offer one symbol and record n cycles of waveform after the accepting edge.
  task automatic trace(input int id, input logic [2:0] s, input int n,
                       output logic [15:0] t_in, output logic [15:0] t_in1,
                       output logic [15:0] t_done, output logic [15:0] t_rdy);
    t_in = '0; t_in1 = '0; t_done = '0; t_rdy = '0;
    @(negedge sys_clk);
    sv[id] = 1'b1;
    sd[id] = s;
    for (int c = 1; c <= n; c++) begin
      @(negedge sys_clk);
      sv[id]      = 1'b0;
      t_in[c-1]   = obs[id][3];
      t_in1[c-1]  = obs[id][2];
      t_done[c-1] = obs[id][0];
      t_rdy[c-1]  = obs[id][4];
    end
  endtask

  // Hold valid high, present symbols 0..nsym-1 only when idle, junk otherwise.
  task automatic b2b(input int id, input int nsym, input int period);
    int nacc;
    int acc_e [8];
    nacc = 0;
    for (int c = 0; c < 200 && nacc < nsym; c++) begin
      @(negedge sys_clk);
      sv[id] = 1'b1;
      if (obs[id][4]) begin
        sd[id] = 3'(nacc);
        acc_e[nacc] = ecnt;
        nacc++;
      end else begin
        sd[id] = 3'($urandom_range(0, 7));
      end
    end
    @(negedge sys_clk);
    sv[id] = 1'b0;
    chk($sformatf("b2b_n%0d", id), 32'(nacc), 32'(nsym));
    for (int i = 1; i < nacc; i++)
      chk($sformatf("b2b_per%0d_%0d", id, i), 32'(acc_e[i] - acc_e[0]), 32'(period * i));
    wait_idle(id);
  endtask

  initial begin
    logic [15:0] t_in, t_in1, t_done, t_rdy;
    logic [2:0]  rr;

    #1 sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("rst_outs0", 32'(obs[0]), 32'h10);
    chk("rst_outs1", 32'(obs[1]), 32'h10);
    sys_rst = 1'b0;

    // Idle for 20 cycles with nothing offered.
    repeat (20) @(negedge sys_clk);
    chk("idle_outs0", 32'(obs[0]), 32'h10);

    // Code 2, tx_in leads.
    trace(0, 3'b010, 9, t_in, t_in1, t_done, t_rdy);
    chk("t2_in",   32'(t_in),   32'h0003);
    chk("t2_in1",  32'(t_in1),  32'h000C);
    chk("t2_done", 32'(t_done), 32'h0100);
    chk("t2_rdy",  32'(t_rdy),  32'h0100);

    // Code 3, tx_in1 leads.
    trace(0, 3'b111, 9, t_in, t_in1, t_done, t_rdy);
    chk("t3a_in",  32'(t_in),  32'h0018);
    chk("t3a_in1", 32'(t_in1), 32'h0003);

    // Code 0 with lead select set: both lines together.
    trace(0, 3'b100, 9, t_in, t_in1, t_done, t_rdy);
    chk("t3b_in",  32'(t_in),  32'h0003);
    chk("t3b_in1", 32'(t_in1), 32'h0003);

    // Back-to-back symbols with junk on sym_data mid-frame.
    b2b(0, 4, 9);

    // Asynchronous reset while the lag line of a code-3 frame is high.
    @(negedge sys_clk);
    sv[0] = 1'b1;
    sd[0] = 3'b011;
    @(posedge sys_clk);
    @(negedge sys_clk);
    sv[0] = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("t5_pre", 32'(obs[0]), 32'h06);
    #1 sys_rst = 1'b1;
    #1;
    chk("t5_async", 32'(obs[0]), 32'h10);
    @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    sv[0] = 1'b1;
    sd[0] = 3'b001;
    for (int e = 0; e < 3; e++) begin
      @(posedge sys_clk);
      #1 rr[2-e] = obs[0][4];
    end
    chk("t5_release", 32'(rr), 32'h6);
    @(negedge sys_clk);
    sv[0] = 1'b0;
    wait_idle(0);

    // Swept parameters: code 2 lag pulse lands in cycle 9, period 15.
    trace(1, 3'b010, 15, t_in, t_in1, t_done, t_rdy);
    chk("t6_in",   32'(t_in),   32'h0001);
    chk("t6_in1",  32'(t_in1),  32'h0100);
    chk("t6_done", 32'(t_done), 32'h4000);
    chk("t6_rdy",  32'(t_rdy),  32'h4000);
    b2b(1, 8, 15);

    // Random traffic on both instances.
    for (int c = 0; c < 400; c++) begin
      @(negedge sys_clk);
      for (int id = 0; id < 2; id++) begin
        sv[id] = ($urandom_range(0, 3) != 0);
        sd[id] = 3'($urandom_range(0, 7));
      end
    end
    @(negedge sys_clk);
    sv = '0;
    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
